// File: rtl/ram_copy_pkg.sv
// Shared constants and FSM state encoding for the RAM copy/fill engine.
package ram_copy_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 10;
    localparam int RAM_DEPTH  = 351;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/copy_addr_gen.sv
// Source/destination pointers and written-word counter for the copy engine.
// Pointers hold on the last word so a descending run ending at 0 never wraps.
module copy_addr_gen
    import ram_copy_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  desc,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] src_init,
    input  logic [ADDR_WIDTH-1:0] dst_init,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic [ADDR_WIDTH-1:0] src_ptr,
    output logic [ADDR_WIDTH-1:0] dst_ptr,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_desc;
    logic                  w_last;

    // Only meaningful while len is non-zero, which holds whenever step is asserted
    assign w_last = (r_cnt == (len - ONE));

    // Pointer load/step and word counting
    always_ff @(posedge clock) begin
        if (reset) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_cnt  <= '0;
            r_desc <= 1'b0;
        end else begin
            if (clr) begin
                r_cnt <= '0;
            end
            if (load) begin
                r_src  <= src_init;
                r_dst  <= dst_init;
                r_desc <= desc;
                r_cnt  <= '0;
            end else if (step) begin
                r_cnt <= r_cnt + ONE;
                if (!w_last) begin
                    r_src <= r_desc ? (r_src - ONE) : (r_src + ONE);
                    r_dst <= r_desc ? (r_dst - ONE) : (r_dst + ONE);
                end
            end
        end
    end

    assign src_ptr = r_src;
    assign dst_ptr = r_dst;
    assign count   = r_cnt;
    assign last    = w_last;

endmodule

// File: rtl/ram_copy_engine.sv
// DMA-style block copy (overlap-safe) / block fill master for the data RAM.
// Copy alternates READ/WRITE per word; fill writes one word per cycle.
module ram_copy_engine
    import ram_copy_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  fill_mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] words_done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_dataC,
    output logic                  ram_writeEnable,
    input  logic [DATA_WIDTH-1:0] ram_dataOutput
);

    localparam logic [ADDR_WIDTH:0] ONE_W     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);

    state_t                r_state;
    state_t                w_next;

    logic                  r_fill;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [DATA_WIDTH-1:0] r_fval;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_len_zero;
    logic [ADDR_WIDTH:0]   w_src_span;
    logic [ADDR_WIDTH:0]   w_src_end;
    logic [ADDR_WIDTH:0]   w_dst_end;
    logic                  w_range_err;
    logic                  w_desc;
    logic [ADDR_WIDTH-1:0] w_src_init;
    logic [ADDR_WIDTH-1:0] w_dst_init;

    logic                  w_clr;
    logic                  w_load;
    logic                  w_step;
    logic [ADDR_WIDTH-1:0] w_src_ptr;
    logic [ADDR_WIDTH-1:0] w_dst_ptr;
    logic [ADDR_WIDTH-1:0] w_count;
    logic                  w_last;

    // Range/overlap evaluation on the latched command; sums are one bit wider so they never wrap
    assign w_accept    = (r_state == IDLE) && start;
    assign w_len_zero  = (r_len == '0);
    assign w_src_span  = {1'b0, r_src} + {1'b0, r_len};
    assign w_src_end   = w_src_span - ONE_W;
    assign w_dst_end   = {1'b0, r_dst} + {1'b0, r_len} - ONE_W;
    assign w_range_err = (w_dst_end > LAST_ADDR) || (!r_fill && (w_src_end > LAST_ADDR));
    // Destination starting inside the source block must be copied from the top down
    assign w_desc      = !r_fill && (r_dst > r_src) && ({1'b0, r_dst} < w_src_span);
    assign w_src_init  = w_desc ? w_src_end[ADDR_WIDTH-1:0] : r_src;
    assign w_dst_init  = w_desc ? w_dst_end[ADDR_WIDTH-1:0] : r_dst;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CHECK;
            CHECK: begin
                if (w_len_zero || w_range_err) w_next = DONE;
                else if (r_fill)               w_next = WRITE;
                else                           w_next = READ;
            end
            READ:    w_next = WRITE;
            WRITE: begin
                if (w_last)      w_next = DONE;
                else if (r_fill) w_next = WRITE;
                else             w_next = READ;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Moore outputs, RAM port mux and address-generator controls
    always_comb begin
        busy            = (r_state != IDLE);
        done            = (r_state == DONE);
        ram_writeEnable = 1'b0;
        ram_address     = '0;
        ram_dataC       = '0;
        w_clr           = w_accept;
        w_load          = (r_state == CHECK) && !w_len_zero && !w_range_err;
        w_step          = 1'b0;
        case (r_state)
            READ: begin
                ram_address = w_src_ptr;
            end
            WRITE: begin
                ram_address     = w_dst_ptr;
                ram_dataC       = r_fill ? r_fval : ram_dataOutput;
                ram_writeEnable = 1'b1;
                w_step          = 1'b1;
            end
            default: ;
        endcase
    end

    // Command latch and sticky range-error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fill <= 1'b0;
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_fval <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fill <= fill_mode;
                r_src  <= src_addr;
                r_dst  <= dst_addr;
                r_len  <= length;
                r_fval <= fill_value;
                r_err  <= 1'b0;
            end else if ((r_state == CHECK) && !w_len_zero && w_range_err) begin
                r_err <= 1'b1;
            end
        end
    end

    copy_addr_gen u_addr_gen (
        .clock    (clock),
        .reset    (reset),
        .clr      (w_clr),
        .load     (w_load),
        .desc     (w_desc),
        .step     (w_step),
        .src_init (w_src_init),
        .dst_init (w_dst_init),
        .len      (r_len),
        .src_ptr  (w_src_ptr),
        .dst_ptr  (w_dst_ptr),
        .count    (w_count),
        .last     (w_last)
    );

    assign error      = r_err;
    assign words_done = w_count;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Scoreboard bench for ram_copy_engine: expected writes/completions are queued
// by the driver and consumed by a monitor watching the RAM port and done.
module tb_ram_copy_engine;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        int         c;
        logic       e;
        logic [9:0] w;
    } dn_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic        fill_mode;
    logic [9:0]  src_addr;
    logic [9:0]  dst_addr;
    logic [9:0]  length;
    logic [31:0] fill_value;
    logic        busy;
    logic        done;
    logic        error;
    logic [9:0]  words_done;
    logic [9:0]  ram_address;
    logic [31:0] ram_dataC;
    logic        ram_writeEnable;
    logic [31:0] ram_dataOutput;

    logic [31:0] mem [0:1023];
    logic        tb_we;
    logic [9:0]  tb_addr;
    logic [31:0] tb_data;

    wr_t wq[$];
    dn_t dq[$];
    int  cyc;
    int  n_chk;
    int  n_err;

    ram_copy_engine dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .fill_mode       (fill_mode),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .length          (length),
        .fill_value      (fill_value),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .words_done      (words_done),
        .ram_address     (ram_address),
        .ram_dataC       (ram_dataC),
        .ram_writeEnable (ram_writeEnable),
        .ram_dataOutput  (ram_dataOutput)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM model with registered read data; bench preload port when DUT not writing
    always @(posedge clock) begin
        if (ram_writeEnable) mem[ram_address] <= ram_dataC;
        else if (tb_we)      mem[tb_addr] <= tb_data;
        ram_dataOutput <= mem[ram_address];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every write and every done pulse must match the head of its queue
    always @(negedge clock) begin
        wr_t w;
        dn_t x;
        if (ram_writeEnable) begin
            if (wq.size() == 0) begin
                chk("unexpected_write_addr", {22'd0, ram_address}, 32'hFFFF_FFFF);
            end else begin
                w = wq.pop_front();
                chk("write_addr", {22'd0, ram_address}, {22'd0, w.a});
                chk("write_data", ram_dataC, w.d);
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                x = dq.pop_front();
                chk("done_cycle", cyc, x.c);
                chk("done_error", {31'd0, error}, {31'd0, x.e});
                chk("done_words", {22'd0, words_done}, {22'd0, x.w});
                chk("done_busy", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic push_w(input logic [9:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        wq.push_back(w);
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clock);
        tb_we = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(negedge clock);
        tb_we = 1'b0;
    endtask

    // Issue one command; k is the expected done cycle counted from the start edge
    task automatic run(input logic fm, input logic [9:0] s, input logic [9:0] d,
                       input logic [9:0] l, input logic [31:0] fv, input logic ee,
                       input int k, input logic [9:0] wd, input logic stray);
        dn_t x;
        bit  seen;
        @(negedge clock);
        start = 1'b1; fill_mode = fm; src_addr = s; dst_addr = d; length = l; fill_value = fv;
        @(posedge clock);
        #1;
        x.c = cyc + k - 1;
        x.e = ee;
        x.w = wd;
        dq.push_back(x);
        @(negedge clock);
        start = 1'b0;
        if (stray) begin
            @(negedge clock);
            chk("busy_mid", {31'd0, busy}, 32'd1);
            start = 1'b1; dst_addr = 10'd0; length = 10'd5;
            @(negedge clock);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clock);
            seen = done;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        @(negedge clock);
        chk("idle_after", {31'd0, busy}, 32'd0);
        chk("error_held", {31'd0, error}, {31'd0, ee});
        chk("words_held", {22'd0, words_done}, {22'd0, wd});
        chk("writes_left", wq.size(), 32'd0);
        chk("dones_left", dq.size(), 32'd0);
    endtask

    initial begin
        cyc = 0; n_chk = 0; n_err = 0;
        reset = 1'b1; start = 1'b0; fill_mode = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_we", {31'd0, ram_writeEnable}, 32'd0);
        chk("rst_words", {22'd0, words_done}, 32'd0);
        chk("rst_addr", {22'd0, ram_address}, 32'd0);
        chk("rst_data", ram_dataC, 32'd0);
        reset = 1'b0;

        // Fill 10..13, with a stray start while busy that must be ignored
        for (int i = 0; i < 4; i++) push_w(10'(10 + i), 32'hDEADBEEF);
        run(1'b1, 10'd0, 10'd10, 10'd4, 32'hDEADBEEF, 1'b0, 6, 10'd4, 1'b1);

        // Ascending copy 0..2 -> 100..102
        preload(10'd0, 32'd1); preload(10'd1, 32'd2); preload(10'd2, 32'd3);
        push_w(10'd100, 32'd1); push_w(10'd101, 32'd2); push_w(10'd102, 32'd3);
        run(1'b0, 10'd0, 10'd100, 10'd3, 32'd0, 1'b0, 8, 10'd3, 1'b0);
        chk("mem100", mem[100], 32'd1);
        chk("mem102", mem[102], 32'd3);

        // Overlapping copy 20..24 -> 22..26 must run top-down
        for (int i = 0; i < 5; i++) preload(10'(20 + i), 32'hA0 + 32'(i));
        for (int i = 4; i >= 0; i--) push_w(10'(22 + i), 32'hA0 + 32'(i));
        run(1'b0, 10'd20, 10'd22, 10'd5, 32'd0, 1'b0, 12, 10'd5, 1'b0);
        chk("mem22", mem[22], 32'hA0);
        chk("mem26", mem[26], 32'hA4);

        // Reverse overlap 22..26 -> 20..24 runs ascending
        for (int i = 0; i < 5; i++) push_w(10'(20 + i), 32'hA0 + 32'(i));
        run(1'b0, 10'd22, 10'd20, 10'd5, 32'd0, 1'b0, 12, 10'd5, 1'b0);
        chk("mem20", mem[20], 32'hA0);
        chk("mem24", mem[24], 32'hA4);

        // Range checks
        run(1'b1, 10'd0, 10'd348, 10'd4, 32'h1111, 1'b1, 2, 10'd0, 1'b0);
        for (int i = 0; i < 4; i++) push_w(10'(347 + i), 32'h5A5A5A5A);
        run(1'b1, 10'd0, 10'd347, 10'd4, 32'h5A5A5A5A, 1'b0, 6, 10'd4, 1'b0);
        chk("mem350", mem[350], 32'h5A5A5A5A);
        run(1'b0, 10'd349, 10'd0, 10'd3, 32'd0, 1'b1, 2, 10'd0, 1'b0);

        // Zero length
        run(1'b0, 10'd5, 10'd6, 10'd0, 32'd0, 1'b0, 2, 10'd0, 1'b0);

        // src == dst copy rewrites each word with itself
        preload(10'd50, 32'h0000_5050); preload(10'd51, 32'h0000_5151);
        push_w(10'd50, 32'h0000_5050); push_w(10'd51, 32'h0000_5151);
        run(1'b0, 10'd50, 10'd50, 10'd2, 32'd0, 1'b0, 6, 10'd2, 1'b0);

        // Reset in cycle 5 of a 10-word copy: only the two writes before it land
        preload(10'd200, 32'h1000); preload(10'd201, 32'h1001);
        push_w(10'd300, 32'h1000); push_w(10'd301, 32'h1001);
        @(negedge clock);
        start = 1'b1; fill_mode = 1'b0; src_addr = 10'd200; dst_addr = 10'd300; length = 10'd10;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_we", {31'd0, ram_writeEnable}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_words", {22'd0, words_done}, 32'd0);
        chk("abort_addr", {22'd0, ram_address}, 32'd0);
        chk("abort_data", ram_dataC, 32'd0);
        chk("abort_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("abort_writes_left", wq.size(), 32'd0);
        chk("mem301", mem[301], 32'h1001);

        // New command accepted after the abort
        push_w(10'd60, 32'h77); push_w(10'd61, 32'h77);
        run(1'b1, 10'd0, 10'd60, 10'd2, 32'h77, 1'b0, 4, 10'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
